// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit pipelined datapath: control-word bit
// positions, opcodes, instruction field positions and the ID/EX state encoding.
package mips_pkg;

  localparam int CTRL_W = 11;

  // Decoder control word {Jump,RegWrite,ALUSrc,MemWrite,ALUOp[2:0],MemtoReg,MemRead,Branch,RegDest}
  localparam int CTRL_JUMP     = 10;
  localparam int CTRL_REGWRITE = 9;
  localparam int CTRL_ALUSRC   = 8;
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_ALUOP_HI = 6;
  localparam int CTRL_ALUOP_LO = 4;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_BRANCH   = 1;
  localparam int CTRL_REGDEST  = 0;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd6,
    OP_SLT = 4'd7,
    OP_LW  = 4'd8,
    OP_SW  = 4'd10,
    OP_BNE = 4'd14
  } opcode_e;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RS_LO  = 10;
  localparam int RT_LO  = 8;
  localparam int RD_LO  = 6;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_HOLD       = 2'd1,
    ST_HOLD_FLUSH = 2'd2,
    ST_BUBBLE     = 2'd3
  } idex_state_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs, EX-side control and the registered EX bundle of the ID/EX stage.
// master drives the decode side and the EX control; slave is the stage itself.
interface id_ex_stage_if
  import mips_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RA_W   = 2,
  parameter int CNT_W  = 16
) ();

  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [DATA_W-1:0] id_pc1;
  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic              ex_flush;
  logic              ex_hold;

  logic              stall;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [RA_W-1:0]   ex_rs;
  logic [RA_W-1:0]   ex_rt;
  logic [RA_W-1:0]   ex_rd;
  logic [DATA_W-1:0] ex_pc1;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_instr, id_pc1, id_ctrl, id_rs_data, id_rt_data,
    output ex_flush, ex_hold,
    input  stall, ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm,
    input  ex_rs, ex_rt, ex_rd, ex_pc1, stall_cnt
  );

  modport slave (
    input  id_valid, id_instr, id_pc1, id_ctrl, id_rs_data, id_rt_data,
    input  ex_flush, ex_hold,
    output stall, ex_valid, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm,
    output ex_rs, ex_rt, ex_rd, ex_pc1, stall_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard: a valid load in EX whose destination (rt) is read by the
// valid instruction in ID. rt counts as a source for R-type ops and for store data.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int RA_W = 2
) (
  input  logic            i_ex_valid,
  input  logic            i_ex_memread,
  input  logic [RA_W-1:0] i_ex_rt,
  input  logic            i_id_valid,
  input  logic [RA_W-1:0] i_id_rs,
  input  logic [RA_W-1:0] i_id_rt,
  input  logic            i_id_alusrc,
  input  logic            i_id_memwrite,
  output logic            o_hz
);

  logic w_load_in_ex;
  logic w_rt_is_src;
  logic w_rs_match;
  logic w_rt_match;

  assign w_load_in_ex = i_ex_valid & i_ex_memread & i_id_valid;
  assign w_rt_is_src  = ~i_id_alusrc | i_id_memwrite;
  assign w_rs_match   = (i_ex_rt == i_id_rs);
  assign w_rt_match   = w_rt_is_src & (i_ex_rt == i_id_rt);

  assign o_hz = w_load_in_ex & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// downstream hold; drives the stall back to PC and IF/ID.
//   state       | meaning
//   RUN         | normal load from ID (or flush bubble just taken)
//   HOLD        | downstream hold active, EX frozen, no flush owed
//   HOLD_FLUSH  | hold active and a flush arrived; bubble owed on release
//   BUBBLE      | load-use bubble inserted on the previous edge
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RA_W   = 2,
  parameter int IMM_W  = 8,
  parameter int CNT_W  = 16
) (
  input logic          i_clk,
  input logic          i_reset,
  id_ex_stage_if.slave bus
);

  idex_state_e       r_state;
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [RA_W-1:0]   r_rs;
  logic [RA_W-1:0]   r_rt;
  logic [RA_W-1:0]   r_rd;
  logic [DATA_W-1:0] r_pc1;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [RA_W-1:0]   w_id_rs;
  logic [RA_W-1:0]   w_id_rt;
  logic [RA_W-1:0]   w_id_rd;
  logic [DATA_W-1:0] w_imm_ext;
  logic [3:0]        w_unused_opcode;
  logic              w_hz;
  logic              w_flush_pend;
  logic              w_flush_any;
  logic              w_hz_bubble;
  logic              w_bubble;
  logic              w_cnt_sat;

  assign w_id_rs         = bus.id_instr[RS_LO +: RA_W];
  assign w_id_rt         = bus.id_instr[RT_LO +: RA_W];
  assign w_id_rd         = bus.id_instr[RD_LO +: RA_W];
  assign w_imm_ext       = {{(DATA_W-IMM_W){bus.id_instr[IMM_W-1]}}, bus.id_instr[IMM_LO +: IMM_W]};
  assign w_unused_opcode = bus.id_instr[OPC_HI:OPC_LO];

  hazard_detect #(.RA_W(RA_W)) u_hazard (
    .i_ex_valid    (r_valid),
    .i_ex_memread  (r_ctrl[CTRL_MEMREAD]),
    .i_ex_rt       (r_rt),
    .i_id_valid    (bus.id_valid),
    .i_id_rs       (w_id_rs),
    .i_id_rt       (w_id_rt),
    .i_id_alusrc   (bus.id_ctrl[CTRL_ALUSRC]),
    .i_id_memwrite (bus.id_ctrl[CTRL_MEMWRITE]),
    .o_hz          (w_hz)
  );

  // A pending or live flush outranks the hazard: fetch must redirect, not stall.
  assign w_flush_pend = (r_state == ST_HOLD_FLUSH);
  assign w_flush_any  = bus.ex_flush | w_flush_pend;
  assign w_hz_bubble  = w_hz & ~w_flush_any;
  assign w_bubble     = w_flush_any | w_hz;
  assign w_cnt_sat    = &r_stall_cnt;

  assign bus.stall = bus.ex_hold | w_hz_bubble;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_pc1       <= '0;
      r_stall_cnt <= '0;
    end else if (bus.ex_hold) begin
      r_state <= w_flush_any ? ST_HOLD_FLUSH : ST_HOLD;
    end else begin
      if (w_bubble) begin
        r_valid   <= 1'b0;
        r_ctrl    <= '0;
        r_rs_data <= '0;
        r_rt_data <= '0;
        r_imm     <= '0;
        r_rs      <= '0;
        r_rt      <= '0;
        r_rd      <= '0;
        r_pc1     <= '0;
      end else begin
        r_valid   <= bus.id_valid;
        r_ctrl    <= bus.id_valid ? bus.id_ctrl : '0;
        r_rs_data <= bus.id_rs_data;
        r_rt_data <= bus.id_rt_data;
        r_imm     <= w_imm_ext;
        r_rs      <= w_id_rs;
        r_rt      <= w_id_rt;
        r_rd      <= w_id_rd;
        r_pc1     <= bus.id_pc1;
      end
      if (w_hz_bubble && !w_cnt_sat) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      r_state <= w_hz_bubble ? ST_BUBBLE : ST_RUN;
    end
  end

  assign bus.ex_valid   = r_valid;
  assign bus.ex_ctrl    = r_ctrl;
  assign bus.ex_rs_data = r_rs_data;
  assign bus.ex_rt_data = r_rt_data;
  assign bus.ex_imm     = r_imm;
  assign bus.ex_rs      = r_rs;
  assign bus.ex_rt      = r_rt;
  assign bus.ex_rd      = r_rd;
  assign bus.ex_pc1     = r_pc1;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for the pipeline/hazard cases,
// hand sequences for hold/flush, reset-mid-hold and counter saturation (CNT_W=4).
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(16), .RA_W(2), .CNT_W(4)) bus ();

  id_ex_stage #(.DATA_W(16), .RA_W(2), .IMM_W(8), .CNT_W(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic        vld;
    logic [15:0] instr;
    logic [15:0] pc1;
    logic [10:0] ctrl;
    logic [15:0] rsd;
    logic [15:0] rtd;
    logic        flush;
    logic        e_stall;
    logic        e_valid;
    logic [10:0] e_ctrl;
    logic [15:0] e_imm;
    logic [1:0]  e_rs;
    logic [1:0]  e_rt;
    logic [1:0]  e_rd;
    logic [15:0] e_pc1;
    logic [15:0] e_rsd;
    logic [15:0] e_rtd;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic [10:0] c, input logic [15:0] a, input logic [15:0] b,
                       input logic fl, input logic hd);
    bus.id_valid   = v;
    bus.id_instr   = ins;
    bus.id_pc1     = pc;
    bus.id_ctrl    = c;
    bus.id_rs_data = a;
    bus.id_rt_data = b;
    bus.ex_flush   = fl;
    bus.ex_hold    = hd;
  endtask

  task automatic check_ex(input string tag, input logic v, input logic [10:0] c,
                          input logic [15:0] imm, input logic [1:0] rs, input logic [1:0] rt,
                          input logic [1:0] rd, input logic [15:0] pc, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] cnt);
    chk({tag, " ex_valid"},   32'(bus.ex_valid),   32'(v));
    chk({tag, " ex_ctrl"},    32'(bus.ex_ctrl),    32'(c));
    chk({tag, " ex_imm"},     32'(bus.ex_imm),     32'(imm));
    chk({tag, " ex_rs"},      32'(bus.ex_rs),      32'(rs));
    chk({tag, " ex_rt"},      32'(bus.ex_rt),      32'(rt));
    chk({tag, " ex_rd"},      32'(bus.ex_rd),      32'(rd));
    chk({tag, " ex_pc1"},     32'(bus.ex_pc1),     32'(pc));
    chk({tag, " ex_rs_data"}, 32'(bus.ex_rs_data), 32'(a));
    chk({tag, " ex_rt_data"}, 32'(bus.ex_rt_data), 32'(b));
    chk({tag, " stall_cnt"},  32'(bus.stall_cnt),  32'(cnt));
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ADD=0x2780 (rs1 rt3 rd2, imm 0x80), LW r1=0x8105, LW r2=0x8207,
    // ALUSrc I-type 0x2603 (rs1 rt2), SW 0xAE01 (rs3 rt2), SUB 0x6140 (rs0 rt1 rd1)
    tv[0]  = '{1'b1, 16'h2780, 16'h0010, 11'h201, 16'h1111, 16'h2222, 1'b0,
               1'b0, 1'b1, 11'h201, 16'hFF80, 2'd1, 2'd3, 2'd2, 16'h0010, 16'h1111, 16'h2222, 4'd0};
    tv[1]  = '{1'b1, 16'h8105, 16'h0011, 11'h30C, 16'h0100, 16'h0000, 1'b0,
               1'b0, 1'b1, 11'h30C, 16'h0005, 2'd0, 2'd1, 2'd0, 16'h0011, 16'h0100, 16'h0000, 4'd0};
    tv[2]  = '{1'b1, 16'h2780, 16'h0012, 11'h201, 16'h3333, 16'h4444, 1'b0,
               1'b1, 1'b0, 11'h000, 16'h0000, 2'd0, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 4'd1};
    tv[3]  = '{1'b1, 16'h2780, 16'h0012, 11'h201, 16'h5555, 16'h4444, 1'b0,
               1'b0, 1'b1, 11'h201, 16'hFF80, 2'd1, 2'd3, 2'd2, 16'h0012, 16'h5555, 16'h4444, 4'd1};
    tv[4]  = '{1'b1, 16'h8207, 16'h0013, 11'h30C, 16'h0000, 16'h0000, 1'b0,
               1'b0, 1'b1, 11'h30C, 16'h0007, 2'd0, 2'd2, 2'd0, 16'h0013, 16'h0000, 16'h0000, 4'd1};
    tv[5]  = '{1'b1, 16'h2603, 16'h0014, 11'h300, 16'h0A0A, 16'h0B0B, 1'b0,
               1'b0, 1'b1, 11'h300, 16'h0003, 2'd1, 2'd2, 2'd0, 16'h0014, 16'h0A0A, 16'h0B0B, 4'd1};
    tv[6]  = '{1'b1, 16'h8207, 16'h0015, 11'h30C, 16'h0000, 16'h0000, 1'b0,
               1'b0, 1'b1, 11'h30C, 16'h0007, 2'd0, 2'd2, 2'd0, 16'h0015, 16'h0000, 16'h0000, 4'd1};
    tv[7]  = '{1'b1, 16'hAE01, 16'h0016, 11'h180, 16'h0C0C, 16'h0D0D, 1'b0,
               1'b1, 1'b0, 11'h000, 16'h0000, 2'd0, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 4'd2};
    tv[8]  = '{1'b1, 16'hAE01, 16'h0016, 11'h180, 16'h0C0C, 16'h0D0D, 1'b0,
               1'b0, 1'b1, 11'h180, 16'h0001, 2'd3, 2'd2, 2'd0, 16'h0016, 16'h0C0C, 16'h0D0D, 4'd2};
    tv[9]  = '{1'b1, 16'h8105, 16'h0017, 11'h30C, 16'h0000, 16'h0000, 1'b0,
               1'b0, 1'b1, 11'h30C, 16'h0005, 2'd0, 2'd1, 2'd0, 16'h0017, 16'h0000, 16'h0000, 4'd2};
    tv[10] = '{1'b1, 16'h2780, 16'h0018, 11'h201, 16'h1234, 16'h5678, 1'b1,
               1'b0, 1'b0, 11'h000, 16'h0000, 2'd0, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 4'd2};
    tv[11] = '{1'b1, 16'h8105, 16'h0019, 11'h30C, 16'h0000, 16'h0000, 1'b0,
               1'b0, 1'b1, 11'h30C, 16'h0005, 2'd0, 2'd1, 2'd0, 16'h0019, 16'h0000, 16'h0000, 4'd2};
    tv[12] = '{1'b0, 16'h2780, 16'h001A, 11'h201, 16'h7777, 16'h8888, 1'b0,
               1'b0, 1'b0, 11'h000, 16'hFF80, 2'd1, 2'd3, 2'd2, 16'h001A, 16'h7777, 16'h8888, 4'd2};
    tv[13] = '{1'b1, 16'h8105, 16'h001B, 11'h30C, 16'h0000, 16'h0000, 1'b0,
               1'b0, 1'b1, 11'h30C, 16'h0005, 2'd0, 2'd1, 2'd0, 16'h001B, 16'h0000, 16'h0000, 4'd2};
    tv[14] = '{1'b1, 16'h6140, 16'h001C, 11'h201, 16'h9999, 16'hAAAA, 1'b0,
               1'b1, 1'b0, 11'h000, 16'h0000, 2'd0, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 4'd3};
    tv[15] = '{1'b1, 16'h6140, 16'h001C, 11'h201, 16'h9999, 16'hAAAA, 1'b0,
               1'b0, 1'b1, 11'h201, 16'h0040, 2'd0, 2'd1, 2'd1, 16'h001C, 16'h9999, 16'hAAAA, 4'd3};

    // Reset for two edges with random ID-side inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'($urandom), 16'($urandom), 16'($urandom), 11'($urandom),
            16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      edge_step();
      chk($sformatf("reset%0d stall", i), 32'(bus.stall), 32'(0));
      check_ex($sformatf("reset%0d", i), 1'b0, 11'h0, 16'h0, 2'd0, 2'd0, 2'd0,
               16'h0, 16'h0, 16'h0, 4'd0);
    end

    // Table: stall checked before the edge, EX contents after it
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(tv[i].vld, tv[i].instr, tv[i].pc1, tv[i].ctrl, tv[i].rsd, tv[i].rtd,
            tv[i].flush, 1'b0);
      #1;
      chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(tv[i].e_stall));
      edge_step();
      check_ex($sformatf("v%0d", i), tv[i].e_valid, tv[i].e_ctrl, tv[i].e_imm, tv[i].e_rs,
               tv[i].e_rt, tv[i].e_rd, tv[i].e_pc1, tv[i].e_rsd, tv[i].e_rtd, tv[i].e_cnt);
    end

    // Hold for 3 cycles with a flush in the middle, dependent ADD waiting in ID
    @(negedge clk);
    drive(1'b1, 16'h8105, 16'h0020, 11'h30C, 16'h0100, 16'h0000, 1'b0, 1'b0);
    edge_step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 16'h2780, 16'h0021, 11'h201, 16'h1111, 16'h2222, (c == 1), 1'b1);
      #1;
      chk($sformatf("hold%0d stall", c), 32'(bus.stall), 32'(1));
      edge_step();
      check_ex($sformatf("hold%0d", c), 1'b1, 11'h30C, 16'h0005, 2'd0, 2'd1, 2'd0,
               16'h0020, 16'h0100, 16'h0000, 4'd3);
    end
    @(negedge clk);
    drive(1'b1, 16'h2780, 16'h0021, 11'h201, 16'h1111, 16'h2222, 1'b0, 1'b0);
    #1;
    chk("release stall", 32'(bus.stall), 32'(0));
    edge_step();
    check_ex("release", 1'b0, 11'h0, 16'h0, 2'd0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0, 4'd3);
    @(negedge clk);
    #1;
    chk("after release stall", 32'(bus.stall), 32'(0));
    edge_step();
    check_ex("after release", 1'b1, 11'h201, 16'hFF80, 2'd1, 2'd3, 2'd2,
             16'h0021, 16'h1111, 16'h2222, 4'd3);

    // Flush captured during hold, then reset: the owed bubble must be forgotten
    @(negedge clk);
    drive(1'b1, 16'h8105, 16'h0022, 11'h30C, 16'h0000, 16'h0000, 1'b0, 1'b0);
    edge_step();
    @(negedge clk);
    drive(1'b1, 16'h2780, 16'h0023, 11'h201, 16'h3333, 16'h4444, 1'b1, 1'b1);
    edge_step();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 16'h2780, 16'h0023, 11'h201, 16'h3333, 16'h4444, 1'b0, 1'b0);
    edge_step();
    check_ex("mid-hold reset", 1'b0, 11'h0, 16'h0, 2'd0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset stall", 32'(bus.stall), 32'(0));
    edge_step();
    check_ex("post-reset load", 1'b1, 11'h201, 16'hFF80, 2'd1, 2'd3, 2'd2,
             16'h0023, 16'h3333, 16'h4444, 4'd0);

    // 2^4+3 load-use pairs: counter must stop at 4'hF
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      drive(1'b1, 16'h8105, 16'h0030, 11'h30C, 16'h0000, 16'h0000, 1'b0, 1'b0);
      edge_step();
      @(negedge clk);
      drive(1'b1, 16'h2780, 16'h0031, 11'h201, 16'h0000, 16'h0000, 1'b0, 1'b0);
      #1;
      chk($sformatf("sat%0d stall", k), 32'(bus.stall), 32'(1));
      edge_step();
      chk($sformatf("sat%0d stall_cnt", k), 32'(bus.stall_cnt), (k > 15) ? 32'd15 : 32'(k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 16-bit pipelined datapath.
- Latches the 11-bit decoder control word together with the register operands, the sign-extended immediate, the register indices and PC+1 into the execute stage.
- Contains load-use hazard detection, bubble insertion, branch flush and downstream hold.
- Drives the stall back to the PC and IF/ID registers.

Parameters:
- DATA_W, 16, datapath and PC width.
- RA_W, 2, register index width (rs=instr[11:10], rt=instr[9:8], rd=instr[7:6]).
- IMM_W, 8, immediate field width (instr[7:0]); sign-extended to DATA_W.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  DATA_W  instruction word (opcode = [15:12]).
- id_pc1  in  DATA_W  PC+1 of the ID instruction.
- id_ctrl  in  11  decoder control word {Jump,RegWrite,ALUSrc,MemWrite,ALUOp[2:0],MemtoReg,MemRead,Branch,RegDest}.
- id_rs_data  in  DATA_W  register-file read port A.
- id_rt_data  in  DATA_W  register-file read port B.
- ex_flush  in  1  branch/jump taken in EX; squash the younger instruction.
- ex_hold  in  1  downstream not ready; freeze this stage.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX contents are real.
- ex_ctrl  out  11  registered control word.
- ex_rs_data, ex_rt_data  out  DATA_W  registered operands.
- ex_imm  out  DATA_W  registered sign-extended immediate.
- ex_rs, ex_rt, ex_rd  out  RA_W  registered register indices.
- ex_pc1  out  DATA_W  registered PC+1.
- stall_cnt  out  CNT_W  number of load-use bubbles inserted; saturates at all-ones.

Behaviour:
- Clocking and reset
  - Single clock; reset is synchronous, active-high.
  - On reset: every registered output = 0 (ex_valid=0, ex_ctrl=0, stall_cnt=0) and flush_pend=0.
- Hazard condition, combinational (hz)
  - Requires ex_valid & ex_ctrl[2] (MemRead) & id_valid.
  - Requires the load destination to match an ID source. The load destination is ex_rt (loads have RegDest=0).
  - Match conditions: ex_rt==id_instr rs field; or ex_rt==id_instr rt field when id_ctrl[8]==0 (ALUSrc=0) or id_ctrl[7]==1 (store data).
- Stall output (combinational): stall = ex_hold | (hz & ~ex_flush & ~flush_pend).
- Per-edge priority, highest first:
  1. reset.
  2. ex_hold: all EX registers hold their value. If ex_flush=1, set flush_pend=1.
  3. ex_flush | flush_pend: insert a bubble (ex_valid=0, ex_ctrl=0, data fields don't-care but driven to 0) and clear flush_pend.
  4. hz: insert a bubble and increment stall_cnt unless it is already saturated.
  5. Otherwise load: ex_valid=id_valid; ex_ctrl = id_valid ? id_ctrl : 0; ex_imm = sign-extend(instr[7:0]); indices and data from their ID inputs.
- Latency: 1 cycle ID→EX. A load-use hazard costs exactly one bubble; the dependent instruction enters EX on the following edge.
- Boundary cases
  - Flush and hazard in the same cycle: the flush wins. stall=0 so fetch redirects; no counter increment.
  - Flush during hold: remembered in flush_pend and applied on the first non-hold edge. A second flush while pending has no extra effect.
  - Reset asserted mid-hold or mid-stall: clears flush_pend and all state on that edge.
  - id_valid=0: a bubble is loaded; the hazard can never fire on an invalid ID instruction.
  - Back-to-back loads with dependency: each dependent pair yields one bubble.
- States (implicit): RUN, HOLD (ex_hold=1), HOLD_FLUSH (flush_pend=1), BUBBLE (the cycle after hz).

Decomposition:
- Shared package (mips_pkg):
  - Control-bit index constants: CTRL_JUMP=10, CTRL_REGWRITE=9, CTRL_ALUSRC=8, CTRL_MEMWRITE=7, CTRL_ALUOP=6:4, CTRL_MEMTOREG=3, CTRL_MEMREAD=2, CTRL_BRANCH=1, CTRL_REGDEST=0.
  - Opcode constants: AND=0, OR=1, ADD=2, SUB=6, SLT=7, LW=8, SW=10, BNE=14.
  - Instruction field position constants.
- One combinational sub-module, hazard_detect (inputs: EX MemRead/valid/rt, ID rs/rt/ALUSrc/MemWrite/valid; output: hz). The register, priority logic and counter stay in id_ex_stage.

Test Plan:
- Reset held 2 cycles with random inputs → all outputs 0 and stall=0; first clean edge loads ADD (0x2...) with ex_ctrl=11'b010_0000_0001.
- LW r1 (ex_rt=1) in EX, then ADD reading rs=1 in ID → stall=1 for one cycle, ex_valid=0, stall_cnt=1; next edge the ADD enters EX with correct operands.
- LW r2 in EX, then an I-type with ALUSrc=1 and rt=2, rs≠2 → no stall. SW with rt=2 → stall=1.
- ex_flush=1 simultaneously with hz=1 → stall=0, bubble loaded, stall_cnt unchanged.
- ex_hold=1 for 3 cycles with ex_flush pulsed in cycle 2 → EX outputs frozen and stall=1. On the first edge after hold drops: bubble loaded, flush_pend cleared.
- Force 2^CNT_W+3 load-use hazards (or CNT_W=4 override) → stall_cnt saturates at all-ones and does not wrap.
